// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the I2C APB requester/completer pair: FSM states and register map.
package apb_i2c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam logic [31:0] ADDR_TX_FIFO = 32'd0;
  localparam logic [31:0] ADDR_RX_FIFO = 32'd4;
  localparam logic [31:0] ADDR_CONFIG  = 32'd8;
  localparam logic [31:0] ADDR_TIMEOUT = 32'd12;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/apb_i2c_requester_if.sv
// Command/response stream plus APB bus seen by the requester (master) and its peers (slave).
interface apb_i2c_requester_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [31:0] CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        RSP_TIMEOUT;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY, PSLVERR,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY, PSLVERR,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expired flags the count-enabled cycle that reaches the limit.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && count != MAX) begin
      count <= count + 1'b1;
    end
  end

  // Fires while the final permitted stall cycle is in progress, so the caller can still let PREADY win.
  assign expired = (TIMEOUT_CYCLES > 0) && count_en && (count == LAST);

endmodule

// File: rtl/apb_i2c_requester.sv
// APB requester: one command at a time becomes a SETUP/ACCESS transfer and a held response.
module apb_i2c_requester
  import apb_i2c_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                  PCLK,
  input logic                  PRESET,
  apb_i2c_requester_if.master  bus
);

  state_t state;
  logic   expired;

  apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (PCLK),
    .rst      (PRESET),
    .clear    (state != ACCESS),
    .count_en (state == ACCESS && !bus.PREADY),
    .expired  (expired)
  );

  // Handshake/bus strobes decode straight from state so an async reset drops them at once.
  assign bus.CMD_READY = (state == IDLE);
  assign bus.PSELx     = (state == SETUP) || (state == ACCESS);
  assign bus.PENABLE   = (state == ACCESS);
  assign bus.RSP_VALID = (state == RESP);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state           <= IDLE;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= '0;
      bus.PWDATA      <= '0;
      bus.RSP_RDATA   <= '0;
      bus.RSP_ERR     <= 1'b0;
      bus.RSP_TIMEOUT <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.CMD_VALID) begin
            bus.PWRITE <= bus.CMD_WRITE;
            bus.PADDR  <= bus.CMD_ADDR;
            bus.PWDATA <= bus.CMD_WDATA;
            if (is_aligned(bus.CMD_ADDR[1:0])) begin
              state <= SETUP;
            end else begin
              bus.RSP_RDATA   <= '0;
              bus.RSP_ERR     <= 1'b1;
              bus.RSP_TIMEOUT <= 1'b0;
              state           <= RESP;
            end
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          if (bus.PREADY) begin
            bus.RSP_RDATA   <= bus.PWRITE ? '0 : bus.PRDATA;
            bus.RSP_ERR     <= bus.PSLVERR;
            bus.RSP_TIMEOUT <= 1'b0;
            state           <= RESP;
          end else if (expired) begin
            bus.RSP_RDATA   <= '0;
            bus.RSP_ERR     <= 1'b1;
            bus.RSP_TIMEOUT <= 1'b1;
            state           <= RESP;
          end
        end
        RESP: begin
          if (bus.RSP_READY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
